// File: rtl/instr_fetch_unit_if.sv
// Instruction-fetch bundle: imem request/response, decode valid/ready and PC redirect.
// master = fetch unit, slave = memory/decode/branch-resolution side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, pc_out, fetch_err,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out, fetch_err,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS fetch stage: holds the PC, fetches one word at a time over req/ack and buffers a
// single instruction for decode; branch/jump redirects squash any fetch already in flight.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                   clk,
    input  logic                   nrst,
    instr_fetch_unit_if.master     bus
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_VALID,
        S_ERR
    } state_t;

    state_t        r_state,    w_state_next;
    logic [31:0]   r_pc,       w_pc_next;
    logic [31:0]   r_pc_tgt,   w_pc_tgt_next;
    logic          r_squash,   w_squash_next;
    logic [CW-1:0] r_wait_cnt, w_wait_next;
    logic [31:0]   r_instr,    w_instr_next;
    logic [31:0]   r_pc_out,   w_pc_out_next;
    logic [31:0]   w_redir_pc;

    assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_pc_tgt_next = r_pc_tgt;
        w_squash_next = r_squash;
        w_wait_next   = r_wait_cnt;
        w_instr_next  = r_instr;
        w_pc_out_next = r_pc_out;

        case (r_state)
            S_IDLE: w_state_next = S_REQ;

            S_REQ: begin
                if (bus.imem_ack) begin
                    w_wait_next = '0;
                    // A redirect in the ack cycle wins over an earlier latched target.
                    if (r_squash || bus.redirect) begin
                        w_pc_next     = bus.redirect ? w_redir_pc : r_pc_tgt;
                        w_squash_next = 1'b0;
                    end else begin
                        w_instr_next  = bus.imem_rdata;
                        w_pc_out_next = r_pc;
                        w_pc_next     = r_pc + 32'd4;
                        w_state_next  = S_VALID;
                    end
                end else begin
                    // Address must stay stable until ack, so the target is parked.
                    if (bus.redirect) begin
                        w_squash_next = 1'b1;
                        w_pc_tgt_next = w_redir_pc;
                    end
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_next = S_ERR;
                        w_wait_next  = '0;
                    end else begin
                        w_wait_next = r_wait_cnt + 1'b1;
                    end
                end
            end

            S_VALID: begin
                if (bus.redirect) begin
                    w_pc_next    = w_redir_pc;
                    w_state_next = S_REQ;
                end else if (bus.instr_ready) begin
                    w_state_next = S_REQ;
                end
            end

            S_ERR: w_state_next = S_ERR;

            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_pc_tgt   <= '0;
            r_squash   <= 1'b0;
            r_wait_cnt <= '0;
            r_instr    <= '0;
            r_pc_out   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_pc_tgt   <= w_pc_tgt_next;
            r_squash   <= w_squash_next;
            r_wait_cnt <= w_wait_next;
            r_instr    <= w_instr_next;
            r_pc_out   <= w_pc_out_next;
        end
    end

    assign bus.imem_req    = (r_state == S_REQ);
    assign bus.instr_valid = (r_state == S_VALID);
    assign bus.fetch_err   = (r_state == S_ERR);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.opcode      = r_instr[31:26];
    assign bus.pc_out      = r_pc_out;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: default instance for fetch/stall/redirect cases,
// second instance with wrapping RESET_PC and short MAX_WAIT for wrap and timeout cases.
module tb_instr_fetch_unit;
    logic clk;
    logic nrst0;
    logic nrst1;
    int   n_checks;
    int   n_pass;

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (16)
    ) u_dut0 (
        .clk  (clk),
        .nrst (nrst0),
        .bus  (bus0.master)
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC),
        .MAX_WAIT (4)
    ) u_dut1 (
        .clk  (clk),
        .nrst (nrst1),
        .bus  (bus1.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        nrst0 = 1'b0;
        nrst1 = 1'b0;
        bus0.imem_ack = 1'b0; bus0.imem_rdata = '0; bus0.instr_ready = 1'b0;
        bus0.redirect = 1'b0; bus0.redirect_pc = '0;
        bus1.imem_ack = 1'b0; bus1.imem_rdata = '0; bus1.instr_ready = 1'b0;
        bus1.redirect = 1'b0; bus1.redirect_pc = '0;
        tick();
        tick();

        // Reset state
        check("rst_req",   32'(bus0.imem_req),    32'd0);
        check("rst_valid", 32'(bus0.instr_valid), 32'd0);
        check("rst_instr", bus0.instr,            32'd0);
        check("rst_pcout", bus0.pc_out,           32'd0);
        check("rst_addr",  bus0.imem_addr,        32'd0);
        check("rst_err",   32'(bus0.fetch_err),   32'd0);

        // Zero-wait streaming, one instruction every second cycle
        nrst0 = 1'b1;
        bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'h2008_0005; bus0.instr_ready = 1'b1;
        tick();
        check("t1_req0",   32'(bus0.imem_req),    32'd1);
        check("t1_addr0",  bus0.imem_addr,        32'h0);
        tick();
        check("t1_valid0", 32'(bus0.instr_valid), 32'd1);
        check("t1_req_v",  32'(bus0.imem_req),    32'd0);
        check("t1_instr0", bus0.instr,            32'h2008_0005);
        check("t1_opc0",   32'(bus0.opcode),      32'h08);
        check("t1_pcout0", bus0.pc_out,           32'h0);
        check("t1_addr1",  bus0.imem_addr,        32'h4);
        tick();
        check("t1_valid1", 32'(bus0.instr_valid), 32'd0);
        check("t1_req1",   32'(bus0.imem_req),    32'd1);
        check("t1_addr1r", bus0.imem_addr,        32'h4);
        bus0.imem_rdata = 32'h8C02_0004;
        tick();
        check("t1_valid2", 32'(bus0.instr_valid), 32'd1);
        check("t1_pcout1", bus0.pc_out,           32'h4);
        check("t1_opc1",   32'(bus0.opcode),      32'h23);
        check("t1_addr2",  bus0.imem_addr,        32'h8);

        // Decode stall holds the buffered instruction
        bus0.instr_ready = 1'b0;
        bus0.imem_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_valid", 32'(bus0.instr_valid), 32'd1);
            check("t2_req",   32'(bus0.imem_req),    32'd0);
            check("t2_instr", bus0.instr,            32'h8C02_0004);
            check("t2_pcout", bus0.pc_out,           32'h4);
            check("t2_addr",  bus0.imem_addr,        32'h8);
        end
        bus0.instr_ready = 1'b1;
        bus0.imem_ack    = 1'b0;
        tick();
        check("t2_release", 32'(bus0.instr_valid), 32'd0);
        check("t2_req8",    32'(bus0.imem_req),    32'd1);

        // Redirect while a fetch is pending: address held, returned word dropped
        bus0.redirect = 1'b1; bus0.redirect_pc = 32'h0000_0043;
        tick();
        bus0.redirect = 1'b0;
        check("t3_hold0", bus0.imem_addr, 32'h8);
        tick();
        check("t3_hold1", bus0.imem_addr, 32'h8);
        tick();
        check("t3_hold2", bus0.imem_addr, 32'h8);
        check("t3_req",   32'(bus0.imem_req), 32'd1);
        bus0.imem_ack = 1'b1; bus0.imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("t3_novalid", 32'(bus0.instr_valid), 32'd0);
        check("t3_newaddr", bus0.imem_addr,        32'h40);
        check("t3_reissue", 32'(bus0.imem_req),    32'd1);
        bus0.imem_rdata = 32'h1000_0003;
        tick();
        check("t3_valid",  32'(bus0.instr_valid), 32'd1);
        check("t3_pcout",  bus0.pc_out,           32'h40);
        check("t3_opc",    32'(bus0.opcode),      32'h04);

        // Redirect in VALID while decode is not ready
        bus0.instr_ready = 1'b0; bus0.redirect = 1'b1; bus0.redirect_pc = 32'h0000_0100;
        tick();
        bus0.redirect = 1'b0; bus0.instr_ready = 1'b1;
        check("t4_dropvalid", 32'(bus0.instr_valid), 32'd0);
        check("t4_addr",      bus0.imem_addr,        32'h100);
        check("t4_req",       32'(bus0.imem_req),    32'd1);
        bus0.imem_rdata = 32'h0000_0020;
        tick();
        check("t4_pcout", bus0.pc_out,    32'h100);
        check("t4_next",  bus0.imem_addr, 32'h104);
        tick();
        // Redirect coinciding with ack: word discarded, target taken directly
        bus0.redirect = 1'b1; bus0.redirect_pc = 32'h0000_0202;
        tick();
        bus0.redirect = 1'b0;
        check("t4_ackredir_valid", 32'(bus0.instr_valid), 32'd0);
        check("t4_ackredir_addr",  bus0.imem_addr,        32'h200);

        // Reset in the middle of a request
        nrst0 = 1'b0;
        tick();
        check("t4_rst_req",   32'(bus0.imem_req),    32'd0);
        check("t4_rst_addr",  bus0.imem_addr,        32'h0);
        check("t4_rst_instr", bus0.instr,            32'h0);

        // PC wrap from the top of the address space
        check("t5_rstaddr", bus1.imem_addr, 32'hFFFF_FFFC);
        nrst1 = 1'b1;
        bus1.imem_ack = 1'b1; bus1.imem_rdata = 32'h0800_0010;
        tick();
        check("t5_addr", bus1.imem_addr, 32'hFFFF_FFFC);
        tick();
        check("t5_pcout", bus1.pc_out,    32'hFFFF_FFFC);
        check("t5_opc",   32'(bus1.opcode), 32'h02);
        check("t5_wrap",  bus1.imem_addr, 32'h0);

        // Fetch timeout with MAX_WAIT=4
        bus1.instr_ready = 1'b1; bus1.imem_ack = 1'b0;
        tick();
        check("t6_req", 32'(bus1.imem_req), 32'd1);
        tick();
        tick();
        tick();
        check("t6_err_early", 32'(bus1.fetch_err), 32'd0);
        check("t6_req_early", 32'(bus1.imem_req),  32'd1);
        tick();
        check("t6_err",    32'(bus1.fetch_err),   32'd1);
        check("t6_err_rq", 32'(bus1.imem_req),    32'd0);
        check("t6_err_v",  32'(bus1.instr_valid), 32'd0);
        bus1.imem_ack = 1'b1;
        tick();
        check("t6_sticky", 32'(bus1.fetch_err), 32'd1);
        nrst1 = 1'b0;
        tick();
        check("t6_clear",  32'(bus1.fetch_err), 32'd0);
        check("t6_rstpc",  bus1.imem_addr,      32'hFFFF_FFFC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
